channel_tx_bridge: RTL and testbench

//  Clocked transmitter end of the 4-phase bundled-data req/ack channel that
//  the pipeline stages consume.

---
 rtl/channel_tx_bridge.sv | 204 ++++++++++++++++++++
 tb/tb_channel_tx_bridge.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/channel_tx_bridge.sv
// channel_tx_bridge: clocked transmitter for a 4-phase bundled-data req/ack
// channel. Words from a valid/ready producer are buffered in a small FIFO,
// placed on ch_data, and each word is sent with one full req+/ack+/req-/ack-
// handshake, with programmable setup (forward) and back-off latencies.
//
// Handshake semantics (producer side): a word transfers on the rising clock
// edge where in_valid && in_ready are both 1. in_ready depends only on
// registered FIFO occupancy, never on in_valid, so the producer may raise or
// drop in_valid at any time without losing or duplicating a word.

module channel_tx_bridge #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int FL_CYC = 2,
  parameter int BL_CYC = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     ch_req,
  output logic [WIDTH-1:0]         ch_data,
  input  logic                     ch_ack,
  output logic [15:0]              tok_count,
  output logic                     busy,
  output logic [2:0]               dbg_state,
  output logic [$clog2(DEPTH):0]   dbg_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [7:0]  FL_LOAD  = 8'(FL_CYC);
  localparam logic [7:0]  BL_LOAD  = 8'(BL_CYC);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_REQ_HI  = 3'd2,
    S_REQ_LO  = 3'd3,
    S_BACKOFF = 3'd4
  } state_e;

  // ack synchronizer
  logic ack_s1_q, ack_s_q;

  // FIFO
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push, pop;
  logic             fifo_empty;

  // FSM and channel registers
  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             ch_req_q, ch_req_d;
  logic [WIDTH-1:0] ch_data_q, ch_data_d;
  logic [15:0]      tok_q, tok_d;

  assign fifo_empty = (count_q == '0);
  assign in_ready   = (count_q != FULL_CNT);
  assign push       = in_valid && in_ready;
  // The only pop point: the edge that drops req after ack+ is seen.
  assign pop        = (state_q == S_REQ_HI) && ack_s_q;

  assign ch_req    = ch_req_q;
  assign ch_data   = ch_data_q;
  assign tok_count = tok_q;
  assign busy      = !fifo_empty || (state_q != S_IDLE);
  assign dbg_state = state_q;
  assign dbg_count = count_q;

  // Two-flop synchronizer bringing the asynchronous ch_ack into clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_s1_q <= 1'b0;
      ack_s_q  <= 1'b0;
    end else begin
      ack_s1_q <= ch_ack;
      ack_s_q  <= ack_s1_q;
    end
  end

  // FIFO storage; contents are logically discarded by the pointer reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  // FIFO pointer and occupancy next-state; pointers wrap modulo DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; only the synchronized ack is observed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (!fifo_empty)   state_d = S_SETUP;
      S_SETUP:   if (cnt_q == '0)   state_d = S_REQ_HI;
      S_REQ_HI:  if (ack_s_q)       state_d = S_REQ_LO;
      S_REQ_LO:  if (!ack_s_q)      state_d = S_BACKOFF;
      S_BACKOFF: if (cnt_q == '0)   state_d = S_IDLE;
      default:                      state_d = S_IDLE;
    endcase
  end

  // FSM output logic: channel data, request, latency counter, token count.
  // ch_data is only reloaded in IDLE, so it holds through REQ_LO.
  always_comb begin
    ch_req_d  = ch_req_q;
    ch_data_d = ch_data_q;
    cnt_d     = cnt_q;
    tok_d     = tok_q;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          ch_data_d = mem_q[rd_ptr_q];
          cnt_d     = FL_LOAD;
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          ch_req_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_REQ_HI: begin
        if (ack_s_q) begin
          ch_req_d = 1'b0;
          tok_d    = tok_q + 16'd1;
        end
      end
      S_REQ_LO: begin
        if (!ack_s_q) begin
          cnt_d = BL_LOAD;
        end
      end
      S_BACKOFF: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        ch_req_d = 1'b0;
      end
    endcase
  end

  // Channel output and counter registers; reset drops ch_req immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_req_q  <= 1'b0;
      ch_data_q <= '0;
      cnt_q     <= '0;
      tok_q     <= '0;
    end else begin
      ch_req_q  <= ch_req_d;
      ch_data_q <= ch_data_d;
      cnt_q     <= cnt_d;
      tok_q     <= tok_d;
    end
  end

endmodule

// File: tb/tb_channel_tx_bridge.sv
// Bench for channel_tx_bridge: directed stimulus, a responder that answers
// the channel with a programmable ack delay, and a monitor that pops the
// expected-word queue on every req+ and checks data hold and token count.

module tb_channel_tx_bridge;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT (FL_CYC=2, BL_CYC=2) ----------------
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        ch_req;
  logic [7:0]  ch_data;
  logic        ch_ack;
  logic [15:0] tok_count;
  logic        busy;
  logic [2:0]  dbg_state;
  logic [2:0]  dbg_count;

  channel_tx_bridge #(.WIDTH(8), .DEPTH(4), .FL_CYC(2), .BL_CYC(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .ch_req(ch_req), .ch_data(ch_data), .ch_ack(ch_ack),
    .tok_count(tok_count), .busy(busy),
    .dbg_state(dbg_state), .dbg_count(dbg_count)
  );

  // ---------------- DUT (FL_CYC=0, BL_CYC=0) ----------------
  logic [7:0]  in_data0 = '0;
  logic        in_valid0 = 1'b0;
  logic        in_ready0;
  logic        ch_req0;
  logic [7:0]  ch_data0;
  logic        ch_ack0 = 1'b0;
  logic [15:0] tok_count0;
  logic        busy0;
  logic [2:0]  dbg_state0;
  logic [2:0]  dbg_count0;

  channel_tx_bridge #(.WIDTH(8), .DEPTH(4), .FL_CYC(0), .BL_CYC(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data0), .in_valid(in_valid0), .in_ready(in_ready0),
    .ch_req(ch_req0), .ch_data(ch_data0), .ch_ack(ch_ack0),
    .tok_count(tok_count0), .busy(busy0),
    .dbg_state(dbg_state0), .dbg_count(dbg_count0)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  int delivered = 0;
  int ack_rise_cyc = 0;
  bit resp_en = 1'b0;
  int ack_dly = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
  endtask

  // ---------------- responder ----------------
  initial begin : responder
    int wait_cnt;
    wait_cnt = 0;
    ch_ack = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        ch_ack = 1'b0;
        wait_cnt = 0;
      end else if (!ch_ack) begin
        if (resp_en && ch_req) begin
          if (wait_cnt >= ack_dly) begin
            ch_ack = 1'b1;
            ack_rise_cyc = cyc;
            wait_cnt = 0;
          end else begin
            wait_cnt++;
          end
        end else begin
          wait_cnt = 0;
        end
      end else if (!ch_req) begin
        ch_ack = 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    logic       prev_req;
    logic [7:0] cap;
    bit         unstable;
    prev_req = 1'b0;
    cap = '0;
    unstable = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_req = 1'b0;
      end else begin
        if (ch_req && !prev_req) begin
          if (exp_q.size() == 0) begin
            timeout("unexpected_word");
          end else begin
            chk("word_order", ch_data, exp_q.pop_front());
          end
          cap = ch_data;
          unstable = 1'b0;
        end else if (ch_req && prev_req) begin
          if (ch_data !== cap) unstable = 1'b1;
        end else if (!ch_req && prev_req) begin
          chk("data_stable_during_req", {31'd0, unstable}, 32'd0);
          chk("data_hold_at_req_fall", ch_data, cap);
          delivered++;
          chk("tok_count_at_req_fall", tok_count, delivered);
          chk("ack_to_req_fall_latency", cyc - ack_rise_cyc, 3);
        end
        prev_req = ch_req;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    resp_en = 1'b0;
    in_valid = 1'b0;
    in_valid0 = 1'b0;
    ch_ack0 = 1'b0;
    exp_q.delete();
    delivered = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic push_word(input logic [7:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data = d;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      timeout("push_word");
      in_valid = 1'b0;
    end else begin
      exp_q.push_back(d);
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_req(input logic lvl, input string name);
    int n;
    n = 0;
    while (ch_req !== lvl && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (ch_req !== lvl) timeout(name);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    if (busy || exp_q.size() != 0) timeout(name);
  endtask

  task automatic wait_req0(input logic lvl, input string name);
    int n;
    n = 0;
    while (ch_req0 !== lvl && n < 200) begin
      @(posedge clk); #3; n++;
    end
    if (ch_req0 !== lvl) timeout(name);
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] t2_words [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

  initial begin : main
    int n;
    do_reset();

    // Reset state.
    chk("rst_ch_req", ch_req, 0);
    chk("rst_ch_data", ch_data, 0);
    chk("rst_tok_count", tok_count, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_fifo_count", dbg_count, 0);
    chk("rst_state_idle", dbg_state, 0);

    // 1: single word, FL_CYC=2 latency.
    resp_en = 1'b1;
    ack_dly = 0;
    push_word(8'hA5);                 // now at E+1ns
    chk("t1_req_low_at_E", ch_req, 0);
    @(posedge clk); #1;               // E+1
    chk("t1_data_at_E1", ch_data, 8'hA5);
    chk("t1_req_low_at_E1", ch_req, 0);
    chk("t1_busy_at_E1", busy, 1);
    @(posedge clk); @(posedge clk); #1; // E+3
    chk("t1_req_low_at_E3", ch_req, 0);
    @(posedge clk); #1;               // E+4
    chk("t1_req_high_at_E4", ch_req, 1);
    wait_drain("t1_drain");
    chk("t1_tok_count", tok_count, 1);
    chk("t1_busy_idle", busy, 0);
    chk("t1_req_low_end", ch_req, 0);

    // 2: fill FIFO with ack withheld, then release.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data = t2_words[i];
      chk("t2_in_ready", in_ready, (i < 4) ? 1 : 0);
      if (in_ready) exp_q.push_back(t2_words[i]);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("t2_full_count", dbg_count, 4);
    chk("t2_full_not_ready", in_ready, 0);
    chk("t2_no_tokens_yet", tok_count, 0);
    resp_en = 1'b1;
    ack_dly = 0;
    push_word(t2_words[4]);
    push_word(t2_words[5]);
    wait_drain("t2_drain");
    chk("t2_tok_count", tok_count, 6);

    // 3: late ack; hold and single pop.
    do_reset();
    resp_en = 1'b1;
    ack_dly = 5;
    push_word(8'hC1);
    push_word(8'hC2);
    wait_req(1'b1, "t3_req_rise");
    chk("t3_count_before_ack", dbg_count, 2);
    repeat (4) begin
      @(posedge clk); #1;
      chk("t3_req_held", ch_req, 1);
      chk("t3_data_held", ch_data, 8'hC1);
    end
    wait_req(1'b0, "t3_req_fall");
    chk("t3_count_after_pop", dbg_count, 1);
    @(posedge clk); #1;
    chk("t3_count_no_double_pop", dbg_count, 1);
    wait_drain("t3_drain");
    chk("t3_tok_count", tok_count, 2);

    // 4: simultaneous push and pop at count 2, then wrap over 10 words.
    do_reset();
    push_word(8'h40);
    push_word(8'h41);
    wait_req(1'b1, "t4_req_rise");
    ack_dly = 0;
    resp_en = 1'b1;
    #2;
    n = 0;
    while (!ch_ack && n < 50) begin
      @(posedge clk); #3; n++;
    end
    if (!ch_ack) timeout("t4_ack_rise");
    @(posedge clk); @(posedge clk); #1;  // ack edge + 2
    chk("t4_count_before_swap", dbg_count, 2);
    in_valid = 1'b1;
    in_data = 8'h42;
    exp_q.push_back(8'h42);
    @(posedge clk); #1;                  // push and pop share this edge
    in_valid = 1'b0;
    chk("t4_req_fell", ch_req, 0);
    chk("t4_count_unchanged", dbg_count, 2);
    ack_dly = 1;
    for (int i = 0; i < 10; i++) push_word(8'h50 + 8'(i));
    wait_drain("t4_drain");
    chk("t4_tok_count", tok_count, 13);

    // 5: reset mid-handshake.
    do_reset();
    resp_en = 1'b1;
    ack_dly = 0;
    push_word(8'h90);
    wait_drain("t5_first_word");
    resp_en = 1'b0;
    push_word(8'h91);
    push_word(8'h92);
    push_word(8'h93);
    wait_req(1'b1, "t5_req_rise");
    chk("t5_count_before_reset", dbg_count, 3);
    chk("t5_tok_before_reset", tok_count, 1);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("t5_req_dropped", ch_req, 0);
    chk("t5_fifo_empty", dbg_count, 0);
    chk("t5_tok_cleared", tok_count, 0);
    chk("t5_in_ready", in_ready, 1);
    chk("t5_busy", busy, 0);
    chk("t5_ch_data_cleared", ch_data, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t5_still_idle", ch_req, 0);

    // 6: FL_CYC=0, BL_CYC=0 instance.
    do_reset();
    in_valid0 = 1'b1;
    in_data0 = 8'hE1;
    chk("t6_in_ready", in_ready0, 1);
    @(posedge clk); #1;                  // E: E1 pushed
    in_data0 = 8'hE2;
    @(posedge clk); #1;                  // E+1: E2 pushed, E1 loaded
    in_valid0 = 1'b0;
    chk("t6_data_at_E1", ch_data0, 8'hE1);
    chk("t6_req_low_at_E1", ch_req0, 0);
    @(posedge clk); #1;                  // E+2
    chk("t6_req_high_at_E2", ch_req0, 1);
    ch_ack0 = 1'b1;
    wait_req0(1'b0, "t6_req_fall");      // at Q+3ns
    ch_ack0 = 1'b0;
    repeat (4) @(posedge clk);
    #1;                                  // Q+4
    chk("t6_data_hold_Q4", ch_data0, 8'hE1);
    @(posedge clk); #1;                  // Q+5
    chk("t6_next_load_Q5", ch_data0, 8'hE2);
    chk("t6_req_low_Q5", ch_req0, 0);
    @(posedge clk); #1;                  // Q+6
    chk("t6_req_high_Q6", ch_req0, 1);
    ch_ack0 = 1'b1;
    wait_req0(1'b0, "t6_req_fall2");
    ch_ack0 = 1'b0;
    n = 0;
    while (busy0 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (busy0) timeout("t6_drain");
    chk("t6_tok_count", tok_count0, 2);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
